// File: rtl/ip_spi_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ip_spi_cmd_pkg
// Brief    : Opcodes and FSM state type shared by the SPI command slave.
// Revision : 1.0 - initial release
// ============================================================================
package ip_spi_cmd_pkg;

    localparam logic [7:0] CMD_PING   = 8'h00;
    localparam logic [7:0] CMD_STOP   = 8'h01;
    localparam logic [7:0] CMD_RUN    = 8'h02;
    localparam logic [7:0] CMD_KEY    = 8'h03;
    localparam logic [7:0] CMD_WRITE  = 8'h04;
    localparam logic [7:0] CMD_STATUS = 8'h05;
    localparam logic [7:0] CMD_RESET  = 8'h06;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        OPCODE   = 3'd1,
        KEY_ROW  = 3'd2,
        KEY_DATA = 3'd3,
        BANK     = 3'd4,
        STREAM   = 3'd5,
        STATUS   = 3'd6,
        IGNORE   = 3'd7
    } state_t;

endpackage
`default_nettype wire

// File: rtl/ip_spi_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ip_spi_cmd_fifo
// Brief    : Synchronous FIFO buffering memory write requests.
// Revision : 1.0 - initial release
// ============================================================================
module ip_spi_cmd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int c_ptr_w = $clog2(DEPTH);
    localparam logic [c_ptr_w:0] c_ptr_one = 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_ptr_w:0] r_wr_ptr;
    logic [c_ptr_w:0] r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    // Extra pointer bit distinguishes full from empty when indices match.
    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[c_ptr_w-1:0] == r_rd_ptr[c_ptr_w-1:0]) &&
                   (r_wr_ptr[c_ptr_w] != r_rd_ptr[c_ptr_w]);

    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);
    assign pop_data  = r_mem[r_rd_ptr[c_ptr_w-1:0]];

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr[c_ptr_w-1:0]] <= push_data;
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ip_spi_cmd_slave.sv
`default_nettype none
// ============================================================================
// Module   : ip_spi_cmd_slave
// Brief    : SPI command slave: key rows, buffered memory writes, CPU control.
// Revision : 1.0 - initial release
// ============================================================================
module ip_spi_cmd_slave
    import ip_spi_cmd_pkg::*;
#(
    parameter int         SPI_MODE   = 3,
    parameter logic [7:0] ACK_BYTE   = 8'hA5,
    parameter int         KEY_ROWS   = 16,
    parameter int         BANK_W     = 8,
    parameter int         OFFS_W     = 13,
    parameter int         FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         n_reset,
    input  logic                         spi_cs_n,
    input  logic                         spi_clk,
    input  logic                         spi_mosi,
    output logic                         spi_miso,
    input  logic                         ready,
    input  logic [7:0]                   status,
    output logic                         key_we,
    output logic [$clog2(KEY_ROWS)-1:0]  key_row,
    output logic [7:0]                   key_data,
    output logic                         mem_valid,
    input  logic                         mem_ready,
    output logic [BANK_W+OFFS_W-1:0]     mem_address,
    output logic [7:0]                   mem_wdata,
    output logic                         cpu_run,
    output logic                         cpu_reset_req,
    output logic                         overflow
);
    localparam int   c_kr_w   = $clog2(KEY_ROWS);
    localparam int   c_fifo_w = BANK_W + OFFS_W + 8;
    localparam logic c_cpol   = 1'((SPI_MODE >> 1) & 1);
    localparam logic c_cpha   = 1'(SPI_MODE & 1);
    localparam logic [OFFS_W-1:0] c_offs_one = 1;

    logic [2:0]          r_cs_sync;
    logic [2:0]          r_sck_sync;
    logic [1:0]          r_mosi_sync;
    state_t              r_state;
    logic [2:0]          r_bit_cnt;
    logic [6:0]          r_shift;
    logic [7:0]          r_tx;
    logic [7:0]          r_resp;
    logic [BANK_W-1:0]   r_bank;
    logic [OFFS_W-1:0]   r_offset;
    logic                r_push;
    logic [c_fifo_w-1:0] r_push_data;

    logic                w_cs_fall;
    logic                w_cs_rise;
    logic                w_sck_rise;
    logic                w_sck_fall;
    logic                w_sample;
    logic                w_shift;
    logic [7:0]          w_byte;
    logic [7:0]          w_resp_start;
    logic [7:0]          w_resp_next;
    logic                w_fifo_full;
    logic                w_fifo_empty;
    logic                w_pop;

    // Index 1 is the synchronised level, index 2 the one-cycle-old copy.
    assign w_cs_fall  =  r_cs_sync[2] & ~r_cs_sync[1];
    assign w_cs_rise  = ~r_cs_sync[2] &  r_cs_sync[1];
    assign w_sck_rise = ~r_sck_sync[2] &  r_sck_sync[1];
    assign w_sck_fall =  r_sck_sync[2] & ~r_sck_sync[1];
    assign w_sample   = (c_cpol ^ c_cpha) ? w_sck_fall : w_sck_rise;
    assign w_shift    = (c_cpol ^ c_cpha) ? w_sck_rise : w_sck_fall;

    assign w_byte       = {r_shift, r_mosi_sync[1]};
    assign w_resp_start = ready ? ACK_BYTE : 8'h00;
    assign w_resp_next  = !ready ? 8'h00 :
                          ((r_state == OPCODE) && (w_byte == CMD_STATUS)) ? status : ACK_BYTE;

    assign spi_miso = r_tx[7];

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            // A low chip select at reset release is not seen as a frame start.
            r_cs_sync     <= '0;
            r_sck_sync    <= {3{c_cpol}};
            r_mosi_sync   <= '0;
            r_state       <= IDLE;
            r_bit_cnt     <= '0;
            r_shift       <= '0;
            r_tx          <= 8'hFF;
            r_resp        <= 8'hFF;
            r_bank        <= '0;
            r_offset      <= '0;
            r_push        <= 1'b0;
            r_push_data   <= '0;
            key_we        <= 1'b0;
            key_row       <= '0;
            key_data      <= 8'hFF;
            cpu_run       <= 1'b0;
            cpu_reset_req <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            r_cs_sync     <= {r_cs_sync[1:0], spi_cs_n};
            r_sck_sync    <= {r_sck_sync[1:0], spi_clk};
            r_mosi_sync   <= {r_mosi_sync[0], spi_mosi};
            key_we        <= 1'b0;
            cpu_reset_req <= 1'b0;
            r_push        <= 1'b0;

            if (r_push && w_fifo_full && !w_pop) begin
                overflow <= 1'b1;
            end

            if (w_cs_fall) begin
                r_state   <= OPCODE;
                r_bit_cnt <= '0;
                r_tx      <= w_resp_start;
                r_resp    <= w_resp_start;
                overflow  <= 1'b0;
            end else if (w_cs_rise) begin
                r_state   <= IDLE;
                r_bit_cnt <= '0;
            end else if (r_state != IDLE) begin
                // Shift edge at a byte boundary presents the next response.
                if (w_shift) begin
                    if (r_bit_cnt == 3'd0) begin
                        r_tx <= r_resp;
                    end else begin
                        r_tx <= {r_tx[6:0], 1'b1};
                    end
                end
                if (w_sample) begin
                    r_shift   <= w_byte[6:0];
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        r_resp <= w_resp_next;
                        case (r_state)
                            OPCODE: begin
                                case (w_byte)
                                    CMD_STOP: begin
                                        cpu_run <= 1'b0;
                                        r_state <= IGNORE;
                                    end
                                    CMD_RUN: begin
                                        cpu_run <= 1'b1;
                                        r_state <= IGNORE;
                                    end
                                    CMD_KEY:    r_state <= KEY_ROW;
                                    CMD_WRITE:  r_state <= BANK;
                                    CMD_STATUS: r_state <= STATUS;
                                    CMD_RESET: begin
                                        cpu_reset_req <= 1'b1;
                                        r_state       <= IGNORE;
                                    end
                                    default:    r_state <= IGNORE;
                                endcase
                            end
                            KEY_ROW: begin
                                key_row <= c_kr_w'(32'(w_byte) % KEY_ROWS);
                                r_state <= KEY_DATA;
                            end
                            KEY_DATA: begin
                                key_data <= w_byte;
                                key_we   <= 1'b1;
                                r_state  <= IGNORE;
                            end
                            BANK: begin
                                r_bank   <= BANK_W'(w_byte);
                                r_offset <= '0;
                                r_state  <= STREAM;
                            end
                            STREAM: begin
                                r_push      <= 1'b1;
                                r_push_data <= {r_bank, r_offset, w_byte};
                                r_offset    <= r_offset + c_offs_one;
                            end
                            default: r_state <= IGNORE;
                        endcase
                    end
                end
            end
        end
    end

    assign mem_valid = !w_fifo_empty;
    assign w_pop     = mem_valid && mem_ready;

    ip_spi_cmd_fifo #(
        .WIDTH (c_fifo_w),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .n_reset   (n_reset),
        .push      (r_push),
        .push_data (r_push_data),
        .pop       (w_pop),
        .pop_data  ({mem_address, mem_wdata}),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty)
    );

endmodule
`default_nettype wire

// File: tb/tb_ip_spi_cmd_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_ip_spi_cmd_slave
// Brief    : Scoreboard bench for ip_spi_cmd_slave in SPI modes 0 and 3.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ip_spi_cmd_slave;
    import ip_spi_cmd_pkg::*;

    localparam int c_half = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       n_reset   = 1'b0;
    logic       mode3     = 1'b0;
    logic       cs_n      = 1'b1;
    logic       sck       = 1'b0;
    logic       mosi      = 1'b0;
    logic       ready     = 1'b1;
    logic       mem_ready = 1'b1;
    logic [7:0] status    = 8'h00;

    logic cs_n0, cs_n3, sck0, sck3;
    assign cs_n0 = mode3 ? 1'b1 : cs_n;
    assign cs_n3 = mode3 ? cs_n : 1'b1;
    assign sck0  = mode3 ? 1'b0 : sck;
    assign sck3  = mode3 ? sck  : 1'b1;

    logic [1:0]  miso, key_we, mem_valid, cpu_run, cpu_reset_req, overflow;
    logic [3:0]  key_row   [2];
    logic [7:0]  key_data  [2];
    logic [20:0] mem_addr  [2];
    logic [7:0]  mem_wdata [2];

    ip_spi_cmd_slave #(.SPI_MODE(0)) u_dut0 (
        .clk(clk), .n_reset(n_reset), .spi_cs_n(cs_n0), .spi_clk(sck0),
        .spi_mosi(mosi), .spi_miso(miso[0]), .ready(ready), .status(status),
        .key_we(key_we[0]), .key_row(key_row[0]), .key_data(key_data[0]),
        .mem_valid(mem_valid[0]), .mem_ready(mem_ready), .mem_address(mem_addr[0]),
        .mem_wdata(mem_wdata[0]), .cpu_run(cpu_run[0]), .cpu_reset_req(cpu_reset_req[0]),
        .overflow(overflow[0]));

    ip_spi_cmd_slave #(.SPI_MODE(3)) u_dut3 (
        .clk(clk), .n_reset(n_reset), .spi_cs_n(cs_n3), .spi_clk(sck3),
        .spi_mosi(mosi), .spi_miso(miso[1]), .ready(ready), .status(status),
        .key_we(key_we[1]), .key_row(key_row[1]), .key_data(key_data[1]),
        .mem_valid(mem_valid[1]), .mem_ready(mem_ready), .mem_address(mem_addr[1]),
        .mem_wdata(mem_wdata[1]), .cpu_run(cpu_run[1]), .cpu_reset_req(cpu_reset_req[1]),
        .overflow(overflow[1]));

    int checks = 0;
    int errors = 0;
    int rst_pending = 0;
    logic [7:0]  q_miso [$];
    logic [11:0] q_key  [$];
    logic [28:0] q_mem  [$];

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic void unexpected(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got an event, expected none", name);
    endfunction

    // MISO monitor: the master samples on the rising edge in both modes.
    int         mon_bits = 0;
    logic [7:0] mon_sr   = 8'h00;
    always @(posedge sck or posedge cs_n) begin
        if (cs_n) begin
            mon_bits = 0;
        end else begin
            mon_sr = {mon_sr[6:0], miso[mode3]};
            mon_bits++;
            if (mon_bits == 8) begin
                mon_bits = 0;
                if (q_miso.size() == 0) unexpected("miso_byte");
                else check("miso_byte", 32'(mon_sr), 32'(q_miso.pop_front()));
            end
        end
    end

    logic        prev_v  = 1'b0;
    logic        prev_r  = 1'b0;
    logic [28:0] prev_ad = '0;
    always @(negedge clk) begin
        if (!n_reset) begin
            prev_v = 1'b0;
        end else begin
            if (key_we[mode3]) begin
                if (q_key.size() == 0) unexpected("key_we");
                else check("key_write", 32'({key_row[mode3], key_data[mode3]}), 32'(q_key.pop_front()));
            end
            if (cpu_reset_req[mode3]) begin
                check("cpu_reset_req_expected", 32'(rst_pending > 0), 32'd1);
                if (rst_pending > 0) rst_pending--;
            end
            if (prev_v && !prev_r)
                check("mem_hold", 32'({mem_valid[mode3], mem_addr[mode3], mem_wdata[mode3]}),
                      32'({1'b1, prev_ad}));
            if (mem_valid[mode3] && mem_ready) begin
                if (q_mem.size() == 0) unexpected("mem_write");
                else check("mem_write", 32'({mem_addr[mode3], mem_wdata[mode3]}), 32'(q_mem.pop_front()));
            end
            prev_v  = mem_valid[mode3];
            prev_r  = mem_ready;
            prev_ad = {mem_addr[mode3], mem_wdata[mode3]};
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bits(input logic [7:0] b, input int nbits);
        for (int i = 7; i > 7 - nbits; i--) begin
            if (mode3) begin
                sck = 1'b0; mosi = b[i]; wait_clk(c_half);
                sck = 1'b1; wait_clk(c_half);
            end else begin
                mosi = b[i]; wait_clk(c_half);
                sck = 1'b1; wait_clk(c_half);
                sck = 1'b0;
            end
        end
    endtask

    task automatic frame_begin();
        cs_n = 1'b0;
        wait_clk(6);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic [7:0] exp);
        q_miso.push_back(exp);
        send_bits(b, 8);
    endtask

    task automatic frame_end();
        wait_clk(c_half);
        cs_n = 1'b1;
        wait_clk(10);
    endtask

    task automatic run_suite(input logic m);
        mode3 = m; sck = m; cs_n = 1'b1; mosi = 1'b0;
        ready = 1'b1; status = 8'h00; mem_ready = 1'b1;
        n_reset = 1'b0;
        wait_clk(4);
        check("rst_miso",      32'(miso[mode3]), 32'd1);
        check("rst_key_we",    32'(key_we[mode3]), 32'd0);
        check("rst_key_row",   32'(key_row[mode3]), 32'd0);
        check("rst_key_data",  32'(key_data[mode3]), 32'hFF);
        check("rst_mem_valid", 32'(mem_valid[mode3]), 32'd0);
        check("rst_mem_addr",  32'(mem_addr[mode3]), 32'd0);
        check("rst_mem_wdata", 32'(mem_wdata[mode3]), 32'd0);
        check("rst_cpu_run",   32'(cpu_run[mode3]), 32'd0);
        check("rst_cpu_rreq",  32'(cpu_reset_req[mode3]), 32'd0);
        check("rst_overflow",  32'(overflow[mode3]), 32'd0);
        n_reset = 1'b1;
        wait_clk(4);

        ready = 1'b0;
        frame_begin(); send_byte(CMD_PING, 8'h00); frame_end();
        ready = 1'b1;
        frame_begin(); send_byte(CMD_PING, 8'hA5); frame_end();

        q_key.push_back({4'd5, 8'h3C});
        frame_begin(); send_byte(CMD_KEY, 8'hA5); send_byte(8'h05, 8'hA5); send_byte(8'h3C, 8'hA5); frame_end();
        q_key.push_back({4'd3, 8'h77});
        frame_begin(); send_byte(CMD_KEY, 8'hA5); send_byte(8'h13, 8'hA5); send_byte(8'h77, 8'hA5); frame_end();

        // Bank 08h, offsets 0..255: address {8'h08, 13'(i)}.
        frame_begin();
        send_byte(CMD_WRITE, 8'hA5);
        send_byte(8'h08, 8'hA5);
        for (int i = 0; i < 256; i++) begin
            q_mem.push_back({8'h08, 13'(i), 8'(i * 7 + 1)});
            send_byte(8'(i * 7 + 1), 8'hA5);
        end
        frame_end();
        wait_clk(10);
        check("stream_overflow", 32'(overflow[mode3]), 32'd0);
        check("stream_drained",  32'(q_mem.size()), 32'd0);

        mem_ready = 1'b0;
        frame_begin();
        send_byte(CMD_WRITE, 8'hA5);
        send_byte(8'h08, 8'hA5);
        for (int i = 0; i < 16; i++) begin
            if (i < 4) q_mem.push_back({8'h08, 13'(i), 8'(8'hC0 + i)});
            send_byte(8'(8'hC0 + i), 8'hA5);
        end
        frame_end();
        check("ovf_flag",      32'(overflow[mode3]), 32'd1);
        check("ovf_valid",     32'(mem_valid[mode3]), 32'd1);
        check("ovf_held",      32'(q_mem.size()), 32'd4);
        mem_ready = 1'b1;
        wait_clk(12);
        check("ovf_released",  32'(q_mem.size()), 32'd0);
        check("ovf_empty",     32'(mem_valid[mode3]), 32'd0);

        status = 8'h01;
        frame_begin(); send_byte(CMD_STATUS, 8'hA5); send_byte(8'h00, 8'h01); frame_end();
        check("ovf_cleared",   32'(overflow[mode3]), 32'd0);
        status = 8'hC3;
        frame_begin(); send_byte(CMD_STATUS, 8'hA5); send_byte(8'h00, 8'hC3); send_byte(8'h00, 8'hA5); frame_end();

        frame_begin(); send_byte(CMD_RUN, 8'hA5); frame_end();
        check("run_set",   32'(cpu_run[mode3]), 32'd1);
        frame_begin(); send_byte(CMD_STOP, 8'hA5); frame_end();
        check("run_clear", 32'(cpu_run[mode3]), 32'd0);
        rst_pending++;
        frame_begin(); send_byte(CMD_RESET, 8'hA5); frame_end();
        check("reset_pulse_seen", 32'(rst_pending), 32'd0);

        // Half an opcode, then a clean run command.
        frame_begin(); send_bits(8'h61, 4); frame_end();
        check("partial_no_effect", 32'(cpu_run[mode3]), 32'd0);
        frame_begin(); send_byte(CMD_RUN, 8'hA5); frame_end();
        check("partial_then_run", 32'(cpu_run[mode3]), 32'd1);

        check("key_q_empty",  32'(q_key.size()), 32'd0);
        check("miso_q_empty", 32'(q_miso.size()), 32'd0);
        check("mem_q_empty",  32'(q_mem.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        run_suite(1'b0);
        run_suite(1'b1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
